// File: rtl/mx_arith_pkg.sv
// Width helpers and signed saturation constants for the MX dot-product datapath.
//   prd_w   : product width from the source FP exponent/mantissa widths
//   sum_w   : adder-tree output width for a given vector length
//   acc_w   : accumulator width for a given maximum group length
//   sat_max : signed maximum of a w-bit value (right-aligned in SAT_MAX_W bits)
//   sat_min : signed minimum of a w-bit value (right-aligned in SAT_MAX_W bits)
package mx_arith_pkg;

   localparam int unsigned SAT_MAX_W = 256;

   function automatic int unsigned prd_w(input int unsigned exp_width,
                                         input int unsigned man_width);
      return 2 * ((32'd1 << exp_width) + man_width);
   endfunction

   function automatic int unsigned sum_w(input int unsigned prd_width,
                                         input int unsigned length);
      return prd_width + $clog2(length);
   endfunction

   function automatic int unsigned acc_w(input int unsigned sum_width,
                                         input int unsigned max_beats);
      return sum_width + $clog2(max_beats);
   endfunction

   // Truncating these to w bits gives 0111..1 and 1000..0.
   function automatic logic [SAT_MAX_W-1:0] sat_max(input int unsigned w);
      return (SAT_MAX_W'(1) << (w - 1)) - SAT_MAX_W'(1);
   endfunction

   function automatic logic [SAT_MAX_W-1:0] sat_min(input int unsigned w);
      return SAT_MAX_W'(1) << (w - 1);
   endfunction

endpackage

// File: rtl/adder_tree_pipe.sv
// Pipelined pairwise adder tree with enable and valid/last sideband.
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_en              : advance every stage when high, hold otherwise
//   i_data            : length signed in_width-bit operands
//   i_valid, i_last   : sideband that travels with the data
//   o_sum             : exact sum, in_width+$clog2(length) bits
//   o_valid, o_last   : sideband aligned with o_sum
// Latency is $clog2(length) enabled cycles; length=1 is a pure pass-through.
module adder_tree_pipe #(
   parameter int unsigned length   = 32,
   parameter int unsigned in_width = 68
) (
   input  logic                                          i_clk,
   input  logic                                          i_rst,
   input  logic                                          i_en,
   input  logic [length-1:0][in_width-1:0]               i_data,
   input  logic                                          i_valid,
   input  logic                                          i_last,
   output logic signed [in_width+$clog2(length)-1:0]     o_sum,
   output logic                                          o_valid,
   output logic                                          o_last
);

   localparam int unsigned D  = $clog2(length);
   localparam int unsigned P  = 1 << D;
   localparam int unsigned OW = in_width + D;

   // Leaves: sign-extended operands, zero-padded up to a power of two.
   logic signed [OW-1:0] leaf [P];

   for (genvar k = 0; k < P; k++) begin : g_leaf
      if (k < length) begin : g_op
         assign leaf[k] = OW'($signed(i_data[k]));
      end else begin : g_pad
         assign leaf[k] = '0;
      end
   end

   if (D > 0) begin : g_tree
      // Heap-ordered nodes: node 1 is the root, children of i are 2i and 2i+1,
      // indices >= P refer to leaves. Every leaf-to-root path crosses D registers.
      logic signed [OW-1:0] node_q [1:P-1];
      logic [D-1:0]         vld_q;
      logic [D-1:0]         lst_q;

      // Data stages; contents are qualified by the valid sideband, so no reset.
      always_ff @(posedge i_clk) begin
         if (i_en) begin
            for (int i = 1; i < int'(P); i++) begin
               if (2 * i >= int'(P)) begin
                  node_q[i] <= leaf[2*i-int'(P)] + leaf[2*i+1-int'(P)];
               end else begin
                  node_q[i] <= node_q[2*i] + node_q[2*i+1];
               end
            end
         end
      end

      // Valid/last shift registers alongside the data stages.
      always_ff @(posedge i_clk) begin
         if (i_rst) begin
            vld_q <= '0;
            lst_q <= '0;
         end else if (i_en) begin
            vld_q[0] <= i_valid;
            lst_q[0] <= i_last;
            for (int s = 1; s < int'(D); s++) begin
               vld_q[s] <= vld_q[s-1];
               lst_q[s] <= lst_q[s-1];
            end
         end
      end

      assign o_sum   = node_q[1];
      assign o_valid = vld_q[D-1];
      assign o_last  = lst_q[D-1];
   end else begin : g_pass
      assign o_sum   = leaf[0];
      assign o_valid = i_valid;
      assign o_last  = i_last;
   end

endmodule

// File: rtl/vec_acc_fp.sv
// Reduction stage of the MX dot-product datapath: sums each product vector in a
// pipelined adder tree, accumulates tree sums over a group ending with i_last,
// and presents one result per group on a valid/ready output.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_prd        : length signed products (prd_width bits each)
//   i_valid      : i_prd/i_last valid;  o_ready: beat accepted this cycle
//   i_last       : final beat of the current group
//   o_sum        : group dot product;  o_valid: o_sum valid;  i_ready: taken
//   o_sat        : group result was clamped (VEC_ACC_FP_SAT_EN builds only)
// Build option VEC_ACC_FP_SAT_EN: saturating accumulate with a sticky per-group
// flag; otherwise the accumulator wraps and o_sat is tied low.
module vec_acc_fp
   import mx_arith_pkg::*;
#(
   parameter int unsigned exp_width = 5,
   parameter int unsigned man_width = 2,
   parameter int unsigned length    = 32,
   parameter int unsigned max_beats = 16,
   parameter int unsigned prd_width = prd_w(exp_width, man_width),
   parameter int unsigned sum_width = sum_w(prd_width, length),
   parameter int unsigned acc_width = acc_w(sum_width, max_beats)
) (
   input  logic                                 i_clk,
   input  logic                                 i_rst,
   input  logic [length-1:0][prd_width-1:0]     i_prd,
   input  logic                                 i_valid,
   input  logic                                 i_last,
   output logic                                 o_ready,
   output logic signed [acc_width-1:0]          o_sum,
   output logic                                 o_valid,
   input  logic                                 i_ready,
   output logic                                 o_sat
);

   logic                        en;
   logic signed [sum_width-1:0] tree_sum;
   logic                        tree_valid;
   logic                        tree_last;

   logic signed [acc_width-1:0] acc_q, acc_d;
   logic                        first_q, first_d;
   logic signed [acc_width-1:0] sum_d;
   logic                        valid_d;
   logic signed [acc_width-1:0] acc_ext;
   logic signed [acc_width-1:0] acc_base;
   logic signed [acc_width-1:0] acc_next;

   // The whole pipeline freezes while a result is waiting on the consumer.
   assign en      = !(o_valid && !i_ready);
   assign o_ready = en;

   adder_tree_pipe #(
      .length   (length),
      .in_width (prd_width)
   ) u_tree (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_en    (en),
      .i_data  (i_prd),
      .i_valid (i_valid),
      .i_last  (i_last),
      .o_sum   (tree_sum),
      .o_valid (tree_valid),
      .o_last  (tree_last)
   );

`ifdef VEC_ACC_FP_SAT_EN
   localparam int unsigned             AW1     = acc_width + 1;
   localparam logic [acc_width-1:0]    ACC_MAX = acc_width'(sat_max(acc_width));
   localparam logic [acc_width-1:0]    ACC_MIN = acc_width'(sat_min(acc_width));

   logic [AW1-1:0] acc_wide;
   logic           sat_hit;
   logic           grp_sat_q, grp_sat_d;
   logic           grp_sat_next;
   logic           osat_d;
`endif

   // Next-state for accumulator, group flags and output register.
   always_comb begin
      acc_ext  = acc_width'(tree_sum);
      acc_base = first_q ? '0 : acc_q;
      acc_d    = acc_q;
      first_d  = first_q;
      sum_d    = o_sum;
      valid_d  = o_valid;
`ifdef VEC_ACC_FP_SAT_EN
      // One extra bit exposes overflow: top two bits disagree.
      acc_wide     = AW1'(acc_base) + AW1'(acc_ext);
      sat_hit      = acc_wide[acc_width] != acc_wide[acc_width-1];
      if (!sat_hit)                acc_next = acc_wide[acc_width-1:0];
      else if (acc_wide[acc_width]) acc_next = ACC_MIN;
      else                          acc_next = ACC_MAX;
      grp_sat_next = (first_q ? 1'b0 : grp_sat_q) | sat_hit;
      grp_sat_d    = grp_sat_q;
      osat_d       = o_sat;
`else
      acc_next = acc_base + acc_ext;
`endif

      if (o_valid && i_ready) valid_d = 1'b0;

      if (en && tree_valid) begin
         if (tree_last) begin
            sum_d   = acc_next;
            valid_d = 1'b1;
            acc_d   = '0;
            first_d = 1'b1;
`ifdef VEC_ACC_FP_SAT_EN
            osat_d    = grp_sat_next;
            grp_sat_d = 1'b0;
`endif
         end else begin
            acc_d   = acc_next;
            first_d = 1'b0;
`ifdef VEC_ACC_FP_SAT_EN
            grp_sat_d = grp_sat_next;
`endif
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         acc_q   <= '0;
         first_q <= 1'b1;
         o_sum   <= '0;
         o_valid <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         first_q <= first_d;
         o_sum   <= sum_d;
         o_valid <= valid_d;
      end
   end

`ifdef VEC_ACC_FP_SAT_EN
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         grp_sat_q <= 1'b0;
         o_sat     <= 1'b0;
      end else begin
         grp_sat_q <= grp_sat_d;
         o_sat     <= osat_d;
      end
   end
`else
   assign o_sat = 1'b0;
`endif

endmodule

// File: tb/tb_vec_acc_fp.sv
// Self-checking bench for vec_acc_fp: directed table, stall/reset/latency
// sequences, randomized groups against a group-sum scoreboard, and a narrow
// length=1 instance exercising accumulator overflow (wrap or saturate).
module tb_vec_acc_fp;

   localparam int unsigned LEN = 32;
   localparam int unsigned PW  = 68;
   localparam int unsigned AW  = 77;
   localparam int unsigned SPW = 8;
   localparam int unsigned SAW = 10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                      rst;
   logic [LEN-1:0][PW-1:0]    i_prd;
   logic                      i_valid, i_last;
   logic                      o_ready, o_valid, o_sat;
   logic signed [AW-1:0]      o_sum;
   logic                      i_ready = 1'b1;

   logic [0:0][SPW-1:0]       s_prd;
   logic                      s_valid, s_last;
   logic                      s_ordy, s_oval, s_osat;
   logic signed [SAW-1:0]     s_osum;

   vec_acc_fp u_dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_prd   (i_prd),
      .i_valid (i_valid),
      .i_last  (i_last),
      .o_ready (o_ready),
      .o_sum   (o_sum),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_sat   (o_sat)
   );

   vec_acc_fp #(
      .length    (1),
      .max_beats (16),
      .prd_width (SPW),
      .acc_width (SAW)
   ) u_sat (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_prd   (s_prd),
      .i_valid (s_valid),
      .i_last  (s_last),
      .o_ready (s_ordy),
      .o_sum   (s_osum),
      .o_valid (s_oval),
      .i_ready (1'b1),
      .o_sat   (s_osat)
   );

   int     tests = 0;
   int     fails = 0;
   longint grp_sum = 0;
   longint exp_q[$];
   bit     rnd_rdy = 1'b0;
   bit     rdy_force = 1'b1;

   task automatic check(input string name, input logic signed [79:0] act,
                        input logic signed [79:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Consumer ready: either forced by the test or randomly toggled.
   always @(posedge clk) begin
      #1;
      i_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : rdy_force;
   end

   // Scoreboard: every completed output transfer must match the oldest group sum.
   always @(negedge clk) begin
      if (!rst && o_valid && i_ready) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_result: got %0d, expected none", o_sum);
         end else begin
            check("sb_sum", o_sum, exp_q.pop_front());
            check("sb_sat", o_sat, 0);
         end
      end
   end

   // One beat: constant value per element, or random elements when rnd=1.
   task automatic send_beat(input bit last, input bit rnd, input int val);
      longint bsum;
      int     e;
      int     n;
      bsum = 0;
      for (int k = 0; k < int'(LEN); k++) begin
         e = rnd ? (int'($urandom_range(0, 4000)) - 2000) : val;
         i_prd[k] = PW'(e);
         bsum += longint'(e);
      end
      i_valid = 1'b1;
      i_last  = last;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!o_ready && n < 200);
      if (!o_ready) begin
         tests++;
         fails++;
         $display("FAIL accept_timeout: got o_ready=0, expected 1");
      end else begin
         grp_sum += bsum;
         if (last) begin
            exp_q.push_back(grp_sum);
            grp_sum = 0;
         end
      end
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      i_last  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("drain", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!o_valid && lat < 60);
   endtask

   typedef struct {
      int     nb;
      int     v0, v1, v2;
      int     bub;
      longint exp;
   } vec_t;

   vec_t tbl[5];

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int lat;
      int nb;
      logic signed [AW-1:0] held;

      tbl[0] = '{nb: 1, v0:  1, v1:  0, v2: 0, bub: 0, exp:  32};
      tbl[1] = '{nb: 3, v0:  2, v1: -1, v2: 3, bub: 0, exp: 128};
      tbl[2] = '{nb: 3, v0:  2, v1: -1, v2: 3, bub: 2, exp: 128};
      tbl[3] = '{nb: 2, v0: -5, v1:  7, v2: 0, bub: 1, exp:  64};
      tbl[4] = '{nb: 1, v0: -3, v1:  0, v2: 0, bub: 0, exp: -96};

      rst = 1'b1; i_valid = 1'b0; i_last = 1'b0; i_prd = '0;
      s_valid = 1'b0; s_last = 1'b0; s_prd = '0;
      idle(3);
      rst = 1'b0;
      @(negedge clk);
      check("rst_valid", o_valid, 0);
      check("rst_sum", o_sum, 0);
      check("rst_sat", o_sat, 0);
      check("rst_ready", o_ready, 1);
      @(posedge clk); #1;

      // Latency: single all-ones beat, counted from the accepting edge.
      send_beat(1'b1, 1'b0, 1);
      wait_valid(lat);
      check("lat_cycles", lat, 6);
      check("lat_sum", o_sum, 32);
      check("lat_sat", o_sat, 0);
      @(negedge clk);
      check("lat_pulse", o_valid, 0);
      drain();

      // Directed table.
      for (int t = 0; t < 5; t++) begin
         for (int b = 0; b < tbl[t].nb; b++) begin
            send_beat(b == tbl[t].nb - 1, 1'b0,
                      (b == 0) ? tbl[t].v0 : (b == 1) ? tbl[t].v1 : tbl[t].v2);
            if (b != tbl[t].nb - 1) idle(tbl[t].bub);
         end
         wait_valid(lat);
         check("tbl_valid", o_valid, 1);
         check("tbl_sum", o_sum, tbl[t].exp);
         @(negedge clk);
         check("tbl_pulse", o_valid, 0);
         drain();
      end

      // Stall: first result held 5 cycles while a second group is in flight.
      rdy_force = 1'b0;
      @(posedge clk); #2;
      send_beat(1'b0, 1'b0, 2);
      send_beat(1'b0, 1'b0, -1);
      send_beat(1'b1, 1'b0, 3);
      send_beat(1'b1, 1'b0, 1);
      wait_valid(lat);
      check("stall_valid", o_valid, 1);
      held = o_sum;
      check("stall_sum", held, 128);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("stall_ready", o_ready, 0);
         check("stall_hold_v", o_valid, 1);
         check("stall_hold_s", o_sum, held);
      end
      rdy_force = 1'b1;
      drain();

      // Reset in the middle of a group discards the partial sum.
      send_beat(1'b0, 1'b0, 2);
      send_beat(1'b0, 1'b0, -1);
      idle(2);
      rst = 1'b1;
      grp_sum = 0;
      idle(1);
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_valid", o_valid, 0);
      @(posedge clk); #1;
      send_beat(1'b1, 1'b0, 1);
      wait_valid(lat);
      check("post_rst_sum", o_sum, 32);
      drain();

      // Randomized groups with bubbles and random backpressure.
      rnd_rdy = 1'b1;
      for (int g = 0; g < 25; g++) begin
         nb = int'($urandom_range(1, 4));
         for (int b = 0; b < nb; b++) begin
            send_beat(b == nb - 1, 1'b1, 0);
            idle(int'($urandom_range(0, 2)));
         end
      end
      rnd_rdy = 1'b0;
      drain();

      // Narrow instance: 16 beats of +127 into a 10-bit accumulator.
      for (int b = 0; b < 16; b++) begin
         s_prd[0] = SPW'(127);
         s_valid  = 1'b1;
         s_last   = (b == 15);
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      lat = 0;
      while (!s_oval && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("ovf_valid", s_oval, 1);
`ifdef VEC_ACC_FP_SAT_EN
      check("ovf_sum", s_osum, 511);
      check("ovf_sat", s_osat, 1);
`else
      check("ovf_sum", s_osum, -16);
      check("ovf_sat", s_osat, 0);
`endif
      @(posedge clk); #1;
      s_prd[0] = SPW'(5);
      s_valid  = 1'b1;
      s_last   = 1'b1;
      @(posedge clk); #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
      @(negedge clk);
      check("next_grp_valid", s_oval, 1);
      check("next_grp_sum", s_osum, 5);
      check("next_grp_sat", s_osat, 0);

      idle(4);
      check("final_queue", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/vec_acc_fp.md
Name: vec_acc_fp

Overview:
- Downstream consumer of the elementwise FP product vector.
- Takes one vector of `length` signed fixed-point products per beat and reduces it through a pipelined, registered adder tree.
- Accumulates tree sums across a group of beats delimited by `i_last`.
- Presents one dot-product result per group on a valid/ready output; it is the reduction stage of the MX dot-product datapath.

Parameters:
- exp_width, 5, exponent width of the source FP elements.
- man_width, 2, mantissa width of the source FP elements.
- length, 32, products per input vector; any value >= 1.
- max_beats, 16, maximum beats per accumulation group; sizes the accumulator.
- prd_width, 2*((1<<exp_width)+man_width), width of each input product (68 by default).
- sum_width, prd_width+$clog2(length), adder-tree output width (73 by default).
- acc_width, sum_width+$clog2(max_beats), accumulator and result width (77 by default).

Ports:
- i_clk  in  1  clock; all logic rising-edge.
- i_rst  in  1  synchronous, active-high reset.
- i_prd  in  signed [prd_width-1:0] x length  product vector.
- i_valid  in  1  i_prd/i_last valid.
- i_last  in  1  final beat of the current group.
- o_ready  out  1  block accepts a beat this cycle.
- o_sum  out  signed [acc_width-1:0]  group dot-product result.
- o_valid  out  1  o_sum valid.
- i_ready  in  1  downstream accepts o_sum.
- o_sat  out  1  result saturated (see Optional Feature).

Behaviour:
- Clocking: single clock `i_clk`. Reset `i_rst` is synchronous, active-high.
- Reset values: o_valid=0, o_sum=0, o_sat=0. All pipeline valid bits 0, accumulator 0, first-beat flag 1.
- Stall rule: enable = !(o_valid && !i_ready); o_ready = enable.
  - When enable=0, every pipeline register, the accumulator and the output hold.
  - A beat is accepted iff i_valid && o_ready.
- Adder tree:
  - The vector is zero-padded to P = 2^$clog2(length) entries.
  - The tree has D = $clog2(length) registered stages; each stage adds adjacent pairs, sign-extended by 1 bit.
  - i_valid and i_last travel with the data in sideband valid/last shift registers.
  - length=1 gives D=0: the product is sign-extended straight to the accumulator stage.
- Accumulator stage, when enabled and the tree output is valid:
  - next = (first ? 0 : acc) + sext(tree_sum).
  - If last=0: acc <= next, first <= 0.
  - If last=1: o_sum <= next, o_valid <= 1, acc <= 0, first <= 1.
- Latency: D+1 enabled cycles from acceptance of the last beat to o_valid=1 (6 cycles at default length 32). Throughput is one beat per cycle when unstalled.
- Output handshake:
  - o_valid && i_ready completes a transfer; o_valid then clears unless a new result loads in the same cycle.
  - If a new result loads in that same cycle, o_sum updates and o_valid stays 1.
  - o_sum and o_valid are stable while o_valid && !i_ready.
- Boundary cases:
  - Single-beat group (i_last on the first beat) is legal.
  - Bubbles (i_valid=0) between beats of a group do not disturb the accumulator.
  - Groups longer than max_beats are undefined in width (wrap or saturate per the feature).
  - Reset mid-group or mid-stall discards all in-flight beats and any partial sum.
- Arithmetic: two's complement throughout. Tree sums are exact (no overflow, by sizing).

Optional Feature:
- Macro: VEC_ACC_FP_SAT_EN.
- Defined:
  - The accumulator add saturates to the signed acc_width max/min.
  - A sticky per-group saturation flag is set when clamping occurs.
  - o_sat presents the flag with o_sum, and the flag clears when the group starts.
- Undefined:
  - Accumulation wraps modulo 2^acc_width.
  - o_sat is tied 0.

Decomposition:
- Package `mx_arith_pkg`:
  - width helper functions for prd_width, sum_width and acc_width;
  - signed saturation constants/functions parameterised by width.
- Sub-module `adder_tree_pipe`:
  - parameterised length and in_width;
  - registered pairwise reduction with enable, valid and last sideband;
  - output width in_width+$clog2(length).
- The accumulator and output register live in `vec_acc_fp`.

Test Plan:
- Single beat, all 32 products = +1, i_last=1, i_ready=1 -> o_valid after 6 cycles, o_sum=32, o_sat=0.
- Group of 3 beats, products all +2, then all -1, then all +3, back-to-back -> one result, o_sum=128; o_valid pulses 1 cycle.
- Same 3-beat group with two i_valid=0 bubbles between beats -> o_sum=128, no extra results.
- Result held with i_ready=0 for 5 cycles while a second group streams -> o_ready=0 during the stall, o_sum stable; both results (128 then 32) delivered in order after i_ready=1.
- i_rst asserted after beat 2 of a 3-beat group, then a fresh 1-beat group of all +1 -> no result for the aborted group, next o_sum=32.
- With VEC_ACC_FP_SAT_EN, 16 beats of max-positive products (length=1, prd_width small override) -> o_sum=signed max, o_sat=1. Without the macro: wrapped value, o_sat=0.
